rv32_run_ctrl: RTL

- Parametrised run controller and completion monitor for the rv32_top 5-stage core.
- Sequences the core reset, bounds the run to a cycle budget, counts cycles and retired instructions, and decodes a tohost-style store into pass/fail/timeout.
- Sits beside rv32_top in simulation and FPGA smoke harnesses. Drives the core's reset input; snoops the data-memory store port and retire strobe.

---
 rtl/rv32_sim_pkg.sv | 17 +
 rtl/rv32_run_ctrl_sat_counter.sv | 16 +
 rtl/rv32_run_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/rv32_sim_pkg.sv
// Shared types and tohost decode for the rv32 simulation/smoke harness blocks.
package rv32_sim_pkg;

  typedef enum logic [1:0] {HOLD, RUN, DONE} run_state_t;

  localparam int TOHOST_PASS = 1;

  typedef enum logic [1:0] {TH_NONE, TH_PASS, TH_FAIL} tohost_kind_e;

  // Callers zero-extend the store data so one decoder serves any XLEN up to 64.
  function automatic tohost_kind_e decode_tohost(input logic [63:0] wdata);
    if (wdata == 64'(TOHOST_PASS)) return TH_PASS;
    else if (wdata[0])             return TH_FAIL;
    else                           return TH_NONE;
  endfunction

endpackage

// File: rtl/rv32_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)                  q <= '0;
    else if (en && (q != '1)) q <= q + 1'b1;
  end

endmodule

// File: rtl/rv32_run_ctrl.sv
// Run controller for rv32_top: sequences core reset, bounds the run to a cycle
// budget, counts cycles/retires and decodes tohost stores into pass/fail/timeout.
module rv32_run_ctrl
  import rv32_sim_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter int               CNT_W       = 32,
  parameter int               RST_CYCLES  = 4,
  parameter int               MAX_CYCLES  = 200,
  parameter logic [XLEN-1:0]  TOHOST_ADDR = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  output logic              core_rst_n,
  input  logic              retire_valid,
  input  logic              dmem_we,
  input  logic [XLEN/8-1:0] dmem_be,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [XLEN-1:0]   dmem_wdata,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [XLEN-2:0]   fail_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_t   state;
  logic [HW-1:0] hold_cnt;
  tohost_kind_e kind;
  logic         hit, last_cycle, in_run, cnt_clr;

  assign in_run     = (state == RUN);
  assign hit        = dmem_we && (&dmem_be) && (dmem_addr == TOHOST_ADDR);
  assign kind       = decode_tohost(64'(dmem_wdata));
  assign last_cycle = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  assign cnt_clr    = !rst_n || ((state == DONE) && restart);

  // The hit edge itself is still a RUN cycle, so both counters advance on it.
  sat_counter #(.W(CNT_W)) u_cycle (
    .clk (clk),
    .clr (cnt_clr),
    .en  (in_run),
    .q   (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .clk (clk),
    .clr (cnt_clr),
    .en  (in_run && retire_valid),
    .q   (instret_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      core_rst_n <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      fail_code  <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HW'(RST_CYCLES - 1)) begin
            state      <= RUN;
            core_rst_n <= 1'b1;
            running    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          // A qualifying store on the final budget cycle beats the timeout.
          if (hit && kind == TH_PASS) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b1;
          end else if (hit && kind == TH_FAIL) begin
            state     <= DONE;
            running   <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= dmem_wdata[XLEN-1:1];
          end else if (last_cycle) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        DONE: begin
          if (restart) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            fail_code  <= '0;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
